mod_writeback_unit: RTL
=======================

Name: mod_writeback_unit

Overview:
- Drives the register file write port (write, write_address, write_data) from two result producers: the single-cycle ALU path and the variable-latency load path.
- The ALU path has strict priority and no backpressure.
- Load results are queued in a small FIFO with a valid/ready handshake and drain whenever the ALU leaves the port free.
- Sits between execute/memory and the register file; also exports the in-flight write for forwarding.

Parameters:
- LOAD_FIFO_DEPTH, 2, number of load-result entries buffered (power of two, ≥2)
- STALL_CNT_W, 16, width of the saturating port-conflict counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- alu_valid  input  1  ALU result present this cycle
- alu_dest  input  5  ALU destination register
- alu_data  input  32  ALU result
- mem_valid  input  1  load result offered
- mem_ready  output  1  load result accepted when mem_valid & mem_ready
- mem_dest  input  5  load destination register
- mem_data  input  32  load data
- write  output  1  register file write enable
- write_address  output  5  register file write address
- write_data  output  32  register file write data
- fifo_count  output  clog2(LOAD_FIFO_DEPTH)+1  occupied load FIFO entries
- stall_count  output  STALL_CNT_W  cycles a queued load was blocked by the ALU

Behaviour:
- Reset (reset==0 at posedge): write=0, write_address=0, write_data=0, FIFO emptied (count=0, pointers=0), stall_count=0. mem_ready is 0 during any cycle with reset low. Reset overrides every other event; in-flight FIFO contents are discarded.
- All outputs except mem_ready are registered. mem_ready = (fifo_count < LOAD_FIFO_DEPTH) & reset, computed from registered count only, with no dependence on the same-cycle pop.
- Load push: mem_valid & mem_ready at edge N writes {mem_dest, mem_data} at the tail.
- Port arbitration each cycle, evaluated on pre-edge state:
  - alu_valid=1: the ALU result is selected.
  - else if FIFO non-empty: the head is selected and popped.
  - else: nothing is selected.
- Latency: an ALU result offered in cycle N appears on write/write_address/write_data in cycle N+1. A load accepted in cycle N is written no earlier than cycle N+2.
- Register $0 suppression: a selected result with dest==0 is consumed (popped if from the FIFO) but produces write=0. write_address and write_data then still update to the selected values.
- Idle cycle: write=0; write_address and write_data hold their previous values.
- Simultaneous push and pop in one cycle is legal (count unchanged); push occurs only when count<DEPTH, so overflow is impossible. Pop from empty cannot occur.
- Pointers wrap modulo LOAD_FIFO_DEPTH. Ordering of loads is strictly FIFO.
- stall_count increments by 1 in each cycle with alu_valid=1 and FIFO non-empty. It saturates at all-ones and never wraps.
- There is no reordering between ALU and load results to the same register. Issue logic guarantees no WAW hazard; this block does not check it.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0
  - wb_entry struct {dest, data}
- One natural sub-module, mod_wb_fifo: a parameterised synchronous FIFO with push/pop/count/head and active-low synchronous reset.
- Arbitration and the stall counter live in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with alu_valid=1, mem_valid=1 -> write=0, write_address=0, write_data=0, fifo_count=0, stall_count=0, mem_ready=0.
- ALU only: alu_valid=1, dest=5, data=0xDEADBEEF at cycle N -> cycle N+1 shows write=1, address=5, data=0xDEADBEEF; cycle N+2 shows write=0.
- Load only: push dest=7, data=0x12345678 at N with alu idle -> fifo_count=1 at N+1; write=1, address=7, data=0x12345678 at N+2; fifo_count=0.
- Conflict and backpressure:
  - Stimulus: alu_valid=1 for 4 cycles while pushing loads dest=1,2,3.
  - Required: mem_ready drops to 0 after 2 accepted; stall_count=3 at the end of the ALU burst.
  - Required after alu_valid drops: loads dest=1 then dest=2 written in consecutive cycles, then dest=3 accepted and written.
- $0 suppression: ALU dest=0, data=0xFFFFFFFF, then load dest=0 -> write stays 0 throughout; the FIFO entry is still popped (fifo_count returns to 0).
- Mid-operation reset: FIFO holding 2 entries, assert reset=0 for 1 cycle -> fifo_count=0, no subsequent write of the discarded entries, mem_ready=1 the cycle after reset releases.

Source files
------------

// File: rtl/mod_writeback_unit_pkg.sv
// Shared types and constants for the writeback unit.
// Purpose : register-file geometry, the zero-register index and the
//           {dest, data} record carried by buffered load results.
// Ports   : none (package).
package mod_writeback_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry;

endpackage

// File: rtl/mod_writeback_unit_if.sv
// Result/writeback bus of the writeback unit.
// Purpose : bundles the ALU result input, the load-result valid/ready
//           handshake and the register-file write port.
// Signals : alu_valid/alu_dest/alu_data     - single-cycle ALU result
//           mem_valid/mem_ready/mem_dest/mem_data - load result handshake
//           write/write_address/write_data  - register-file write port
// Modports: master - the surrounding pipeline / register file side
//           slave  - the writeback unit itself
interface mod_writeback_unit_if;
  import mod_writeback_unit_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0]     alu_data;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0]     mem_data;

  logic                  write;
  logic [REG_ADDR_W-1:0] write_address;
  logic [DATA_W-1:0]     write_data;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    input  mem_ready,
    input  write, write_address, write_data
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    output mem_ready,
    output write, write_address, write_data
  );

endinterface

// File: rtl/mod_writeback_unit_wb_fifo.sv
// mod_wb_fifo: small synchronous FIFO of pending load results.
// Purpose : buffers {dest, data} records until the register-file port
//           is free. Pointers wrap naturally (DEPTH is a power of two).
// Ports   : clk, reset (sync, active-low), push/push_entry (write tail),
//           pop (advance head), head (current oldest entry),
//           count (occupied entries, 0..DEPTH).
// The caller guarantees no push when full and no pop when empty.
module mod_wb_fifo
  import mod_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry                push_entry,
  input  logic                   pop,
  output wb_entry                head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry         storage [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Storage is not reset: entries are only visible through count, so
  // clearing the pointers and count is enough to discard them.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head = storage[rd_ptr];

endmodule

// File: rtl/mod_writeback_unit.sv
// mod_writeback_unit: register-file write port arbiter.
// Purpose : ALU results take the port with strict priority; load results
//           are queued in mod_wb_fifo and drained whenever the ALU leaves
//           the port idle. Writes to register 0 are consumed silently.
// Ports   : clk, reset (sync, active-low)
//           bus         - mod_writeback_unit_if.slave (ALU in, load
//                         handshake, register-file write port)
//           fifo_count  - occupied load-FIFO entries
//           stall_count - saturating count of cycles a queued load was
//                         blocked by an ALU result
module mod_writeback_unit
  import mod_writeback_unit_pkg::*;
#(
  parameter int LOAD_FIFO_DEPTH = 2,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  mod_writeback_unit_if.slave              bus,
  output logic [$clog2(LOAD_FIFO_DEPTH):0] fifo_count,
  output logic [STALL_CNT_W-1:0]           stall_count
);

  localparam int CW = $clog2(LOAD_FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]          DEPTH_CNT = CW'(LOAD_FIFO_DEPTH);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  wb_entry fifo_head;
  wb_entry push_entry;
  logic    fifo_empty;
  logic    push;
  logic    pop;
  logic    sel_valid;
  wb_entry sel_entry;

  // Ready depends only on the registered count so that the producer never
  // sees a combinational path through this cycle's arbitration.
  assign bus.mem_ready = (fifo_count < DEPTH_CNT) & reset;

  assign push       = bus.mem_valid & bus.mem_ready;
  assign push_entry = '{dest: bus.mem_dest, data: bus.mem_data};
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !bus.alu_valid && !fifo_empty;

  mod_wb_fifo #(
    .DEPTH (LOAD_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_entry = fifo_head;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{dest: bus.alu_dest, data: bus.alu_data};
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
    end
  end

  // A selected result always updates address/data, even when the write
  // itself is suppressed for register 0; idle cycles hold them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.write         <= 1'b0;
      bus.write_address <= '0;
      bus.write_data    <= '0;
    end else if (sel_valid) begin
      bus.write         <= (sel_entry.dest != ZERO_REG);
      bus.write_address <= sel_entry.dest;
      bus.write_data    <= sel_entry.data;
    end else begin
      bus.write         <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (bus.alu_valid && !fifo_empty && stall_count != STALL_MAX) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule
